// File: rtl/hps_connection_name_sink.sv
// Avalon-MM slave: HPS writes 32-bit words into a word FIFO; an unpacker emits
// them little-endian as bytes on a valid/ready stream with an end-of-name marker.
module hps_connection_name_sink #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  // entry = {word[31:0], last, nbytes[2:0]}
  logic [35:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    tail_q, tail_d;
  logic [15:0]   sent_q, sent_d;
  state_t        state_q, state_d;
  logic [31:0]   word_q, word_d;
  logic          last_q, last_d;
  logic [1:0]    lidx_q, lidx_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   rdata_q, rdata_d;

  logic        wr_en, empty, full, push_req, push_ok, flush, fire, pop, busy;
  logic [2:0]  push_nb;
  logic [35:0] head;

  always_comb begin
    wr_en    = chipselect & ~write_n;
    empty    = (level_q == 8'd0);
    full     = (level_q == 8'(DEPTH));
    push_req = wr_en & ~address[1];
    push_ok  = push_req & ~full;
    flush    = wr_en & (address == 2'd3) & writedata[0];
    busy     = (state_q == ST_EMIT);
    fire     = busy & out_ready;
    head     = mem_q[rd_ptr_q];
    push_nb  = (address[0] && tail_q != 2'd0) ? {1'b0, tail_q} : 3'd4;
  end

  // unpacker next state; a pop loads the FIFO head into the holding register
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    last_d  = last_q;
    lidx_d  = lidx_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (fire) begin
          if (idx_q == lidx_q) begin
            if (!empty) pop = 1'b1;
            else        state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) begin
      word_d = head[35:4];
      last_d = head[3];
      lidx_d = 2'(head[2:0] - 3'd1);
      idx_d  = 2'd0;
    end
    if (flush) begin
      pop     = 1'b0;
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = 8'd0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + 8'(push_ok) - 8'(pop);
    end
    ovf_d = ovf_q;
    if (push_req && full) ovf_d = 1'b1;
    if (wr_en && address == 2'd3 && writedata[1]) ovf_d = 1'b0;
    tail_d = tail_q;
    if (wr_en && address == 2'd2) tail_d = writedata[1:0];
    sent_d = sent_q + 16'(fire);
    case (address)
      2'd0:    rdata_d = {16'h0, level_q, 4'h0, busy, ovf_q, full, empty};
      2'd1:    rdata_d = {16'h0, sent_q};
      2'd2:    rdata_d = {30'h0, tail_q};
      default: rdata_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {writedata, address[0], push_nb};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= 8'd0;
      ovf_q    <= 1'b0;
      tail_q   <= 2'd0;
      sent_q   <= 16'd0;
      state_q  <= ST_IDLE;
      word_q   <= 32'h0;
      last_q   <= 1'b0;
      lidx_q   <= 2'd0;
      idx_q    <= 2'd0;
      rdata_q  <= 32'h0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      tail_q   <= tail_d;
      sent_q   <= sent_d;
      state_q  <= state_d;
      word_q   <= word_d;
      last_q   <= last_d;
      lidx_q   <= lidx_d;
      idx_q    <= idx_d;
      rdata_q  <= rdata_d;
    end
  end

  assign readdata  = rdata_q;
  assign out_valid = busy;
  assign out_data  = busy ? word_q[{idx_q, 3'b000} +: 8] : 8'h00;
  assign out_last  = busy & last_q & (idx_q == lidx_q);

endmodule

// File: tb/tb_hps_connection_name_sink.sv
// Bench for hps_connection_name_sink: register vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_hps_connection_name_sink;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, chipselect, write_n, out_ready, out_valid, out_last;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;
  logic [7:0]  out_data;

  hps_connection_name_sink #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write_n(write_n),
    .address(address), .writedata(writedata), .readdata(readdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] w;
    logic        last;
    int          n;
  } word_t;

  typedef struct {
    bit          do_wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  // reference model: queued words plus the bytes still owed from the held word
  word_t       wq[$];
  logic [7:0]  hb[$];
  logic        hlast;
  logic        m_ovf;
  logic [1:0]  m_tail;
  logic [15:0] m_sent;
  logic [31:0] rd_exp;
  bit          mdl_ok = 0;

  int nchk = 0, nerr = 0, ncyc = 0, rdy_mode = 0, fv = -1;
  logic [8:0] got[$];
  int         acc_cyc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  task automatic model_edge();
    bit    wr, fire, full, flush, busy, empty;
    word_t h;
    if (reset) begin
      wq.delete(); hb.delete();
      hlast = 0; m_ovf = 0; m_tail = 0; m_sent = 0; rd_exp = 0; mdl_ok = 1;
      return;
    end
    if (!mdl_ok) return;
    busy  = (hb.size() != 0);
    empty = (wq.size() == 0);
    full  = (wq.size() == DEPTH);
    case (address)
      2'd0:    rd_exp = {16'h0, 8'(wq.size()), 4'h0, busy, m_ovf, full, empty};
      2'd1:    rd_exp = {16'h0, m_sent};
      2'd2:    rd_exp = {30'h0, m_tail};
      default: rd_exp = 32'h0;
    endcase
    wr   = chipselect && !write_n;
    fire = busy && out_ready;
    if (fire) begin
      m_sent++;
      void'(hb.pop_front());
    end
    flush = wr && address == 2'd3 && writedata[0];
    if (flush) begin
      wq.delete(); hb.delete();
    end else if (hb.size() == 0 && wq.size() > 0) begin
      h = wq.pop_front();
      for (int i = 0; i < h.n; i++) hb.push_back(h.w[8*i +: 8]);
      hlast = h.last;
    end
    if (wr && address < 2'd2) begin
      if (full) m_ovf = 1;
      else begin
        h.w    = writedata;
        h.last = address[0];
        h.n    = (address[0] && m_tail != 2'd0) ? int'(m_tail) : 4;
        wq.push_back(h);
      end
    end
    if (wr && address == 2'd2) m_tail = writedata[1:0];
    if (wr && address == 2'd3 && writedata[1]) m_ovf = 0;
  endtask

  task automatic cyc();
    if (rdy_mode == 1)      out_ready = ((ncyc % 2) == 0);
    else if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
    if (mdl_ok && !reset) begin
      chk("out_valid", 32'(out_valid), 32'(hb.size() != 0));
      if (hb.size() != 0) begin
        chk("out_data", 32'(out_data), 32'(hb[0]));
        chk("out_last", 32'(out_last), 32'(hlast && hb.size() == 1));
      end
      chk("readdata", readdata, rd_exp);
    end
    if (out_valid && out_ready) begin
      got.push_back({out_last, out_data});
      acc_cyc.push_back(ncyc);
    end
    if (out_valid && fv < 0) fv = ncyc;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    ncyc++;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    cyc();
    chipselect = 0; write_n = 1; writedata = 32'h0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address = a;
    cyc();
    v = readdata;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  vec_t        vt[8];
  logic [31:0] v;
  logic [7:0]  kb;
  int          t0;

  initial begin
    vt[0] = '{0, 2'd0, 32'h0,        2'd0, 32'h1};
    vt[1] = '{0, 2'd0, 32'h0,        2'd3, 32'h0};
    vt[2] = '{1, 2'd2, 32'hFFFFFFFE, 2'd2, 32'h2};
    vt[3] = '{1, 2'd2, 32'h00000005, 2'd2, 32'h1};
    vt[4] = '{1, 2'd2, 32'h00000003, 2'd2, 32'h3};
    vt[5] = '{1, 2'd3, 32'hFFFFFFFC, 2'd3, 32'h0};
    vt[6] = '{1, 2'd2, 32'h00000000, 2'd2, 32'h0};
    vt[7] = '{0, 2'd0, 32'h0,        2'd1, 32'h0};

    // reset held two cycles while a write is presented
    reset = 1; chipselect = 1; write_n = 0; address = 2'd1;
    writedata = 32'hDEADBEEF; out_ready = 1;
    @(negedge clk);
    cyc(); cyc();
    reset = 0; chipselect = 0; write_n = 1; address = 2'd0; writedata = 0;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_out_last",  32'(out_last),  32'h0);
    chk("rst_readdata",  readdata,       32'h0);
    rd(2'd0, v);
    chk("rst_status", v, 32'h00000001);

    for (int i = 0; i < 8; i++) begin
      if (vt[i].do_wr) wr(vt[i].waddr, vt[i].wdata);
      rd(vt[i].raddr, v);
      chk($sformatf("reg_vec%0d", i), v, vt[i].exp);
    end

    // single final word, full 4 bytes
    wr(2'd2, 32'h0);
    out_ready = 1; got.delete(); acc_cyc.delete(); fv = -1;
    t0 = ncyc;
    wr(2'd1, 32'h64636261);
    idle(8);
    chk("single_first_valid", 32'(fv), 32'(t0 + 2));
    chk("single_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      chk("single_b0", 32'(got[0]), 32'h061);
      chk("single_b1", 32'(got[1]), 32'h062);
      chk("single_b2", 32'(got[2]), 32'h063);
      chk("single_b3", 32'(got[3]), 32'h164);
      chk("single_consecutive", 32'(acc_cyc[3] - acc_cyc[0]), 32'd3);
    end
    rd(2'd1, v);
    chk("single_sent", v, 32'd4);

    // tail of 3 bytes
    wr(2'd2, 32'h3);
    got.delete();
    wr(2'd1, 32'h00434241);
    idle(8);
    chk("tail_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      chk("tail_b0", 32'(got[0]), 32'h041);
      chk("tail_b1", 32'(got[1]), 32'h042);
      chk("tail_b2", 32'(got[2]), 32'h143);
    end
    rd(2'd1, v);
    chk("tail_sent", v, 32'd7);

    // backpressure with alternating ready
    got.delete(); rdy_mode = 1;
    wr(2'd0, 32'h44332211);
    wr(2'd0, 32'h88776655);
    idle(30);
    rdy_mode = 0; out_ready = 1;
    chk("bp_count", 32'(got.size()), 32'd8);
    for (int k = 0; k < got.size() && k < 8; k++)
      chk($sformatf("bp_b%0d", k), 32'(got[k]), 32'(17 * (k + 1)));
    rd(2'd1, v);
    chk("bp_sent", v, 32'd15);

    // back-to-back words with ready held high: no bubble
    got.delete(); acc_cyc.delete();
    wr(2'd0, 32'h44332211);
    wr(2'd0, 32'h88776655);
    idle(12);
    chk("b2b_count", 32'(got.size()), 32'd8);
    if (acc_cyc.size() == 8) chk("b2b_no_bubble", 32'(acc_cyc[7] - acc_cyc[0]), 32'd7);
    rd(2'd1, v);
    chk("b2b_sent", v, 32'd23);

    // overflow: one word in the unpacker, DEPTH queued, one dropped
    out_ready = 0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      kb = 8'(k);
      wr(2'd0, {4{kb}});
    end
    rd(2'd0, v);
    chk("ovf_status", v, (32'(DEPTH) << 8) | 32'hE);
    wr(2'd3, 32'h2);
    rd(2'd0, v);
    chk("ovf_cleared", v, (32'(DEPTH) << 8) | 32'hA);
    got.delete(); out_ready = 1;
    idle(4 * (DEPTH + 1) + 6);
    chk("ovf_drain_count", 32'(got.size()), 32'(4 * (DEPTH + 1)));
    if (got.size() == 4 * (DEPTH + 1))
      chk("ovf_drain_lastword", 32'(got[4 * DEPTH + 3]), 32'(DEPTH));
    rd(2'd1, v);
    chk("ovf_sent", v, 32'd59);

    // flush mid-name: one word held, three queued, at byte 2
    out_ready = 0;
    wr(2'd0, 32'hA4A3A2A1);
    wr(2'd0, 32'hB4B3B2B1);
    wr(2'd0, 32'hC4C3C2C1);
    wr(2'd0, 32'hD4D3D2D1);
    out_ready = 1;
    cyc();
    out_ready = 0;
    chk("flush_pre_valid", 32'(out_valid), 32'h1);
    chk("flush_pre_data", 32'(out_data), 32'hA2);
    wr(2'd3, 32'h1);
    chk("flush_valid_drop", 32'(out_valid), 32'h0);
    rd(2'd0, v);
    chk("flush_status", v, 32'h00000001);
    rd(2'd1, v);
    chk("flush_sent", v, 32'd60);
    wr(2'd2, 32'h0);
    out_ready = 1; got.delete();
    wr(2'd1, 32'h11223344);
    idle(8);
    chk("post_flush_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) begin
      chk("post_flush_b0", 32'(got[0]), 32'h044);
      chk("post_flush_b3", 32'(got[3]), 32'h111);
    end
    rd(2'd1, v);
    chk("post_flush_sent", v, 32'd64);

    // randomized traffic against the model
    rdy_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 7)       wr(2'($urandom_range(0, 2)), $urandom);
      else if (r == 7) wr(2'd3, ($urandom_range(0, 3) == 0) ? 32'h1 : 32'h2);
      else             rd(2'($urandom_range(0, 3)), v);
    end
    rdy_mode = 0; out_ready = 1;
    idle(4 * (DEPTH + 1) + 8);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/hps_connection_name_sink.md
# hps_connection_name_sink

Avalon-MM slave that carries a byte-oriented name stream from the HPS into the FPGA fabric, opposite in direction to the existing read-only name-stream input port. The HPS writes 32-bit words into a small word FIFO. An unpacker emits them as bytes, little-endian, on a valid/ready stream with an end-of-name marker. A status register gives software fill level, overflow and progress.

## Interface

Parameters:
- `DEPTH`, 8: FIFO depth in 32-bit words; power of two, 2..128.

Ports:
- `clk`, in, 1: single clock for the whole block.
- `reset`, in, 1: synchronous, active-high reset.
- `chipselect`, in, 1: Avalon slave select.
- `write_n`, in, 1: active-low write strobe; a write occurs when `chipselect & ~write_n`.
- `address`, in, 2: register select.
- `writedata`, in, 32: write data.
- `readdata`, out, 32: registered read data.
- `out_data`, out, 8: stream byte.
- `out_valid`, out, 1: `out_data` and `out_last` are valid.
- `out_ready`, in, 1: sink accepts the byte.
- `out_last`, out, 1: final byte of a name.

## Operation

Register map:
- addr 0, write: push `writedata` as a normal word (`last=0`, 4 bytes).
- addr 0, read: status word.
  - bit0 empty, bit1 full, bit2 overflow (sticky), bit3 busy (unpacker holds a word).
  - bits[15:8] FIFO level in words.
  - All other bits 0.
- addr 1, write: push `writedata` as the final word of a name (`last=1`). Its byte count is taken from `tail_bytes` at push time.
- addr 1, read: bits[15:0] `bytes_sent`, the count of accepted stream bytes; wraps mod 2^16; upper bits 0.
- addr 2, write/read: `tail_bytes` in bits[1:0]. 0 means 4 bytes; 1..3 mean 1..3 bytes. Upper bits ignored on write and read as 0.
- addr 3, write:
  - bit0 flush: empty the FIFO, drop the word held by the unpacker, go to IDLE.
  - bit1 clear overflow.
  - `bytes_sent` is not affected.
- addr 3, read: 0.

FIFO:
- Each entry is {word[31:0], last, nbytes[2:0]}.
- A push while full is dropped and sets overflow. This applies even if the unpacker pops in the same cycle.
- A push and a pop in the same cycle when not full: level is unchanged.

Unpacker FSM:
- IDLE:
  - `out_valid=0`.
  - If the FIFO is not empty: pop the head into the holding register, set `idx=0`, go to EMIT.
- EMIT:
  - `out_valid=1`, `out_data=word[8*idx+7:8*idx]`, `out_last = last & (idx==nbytes-1)`.
  - On `out_valid & out_ready`:
    - `bytes_sent` increments.
    - If `idx==nbytes-1`: pop the next word in the same cycle if the FIFO is not empty (stay in EMIT, `idx=0`); otherwise go to IDLE.
    - Else `idx` increments.
  - `out_data`, `out_last` and `out_valid` are held stable while `out_valid & ~out_ready`.
- Flush: takes effect on the edge of the addr-3 write. `out_valid` is 0 from the next cycle, even mid-name. This is the one permitted break of the valid-hold rule.

Reset values (on a `reset`-high edge):
- `readdata`=0, `out_valid`=0, `out_data`=0, `out_last`=0.
- FIFO empty, overflow=0, `tail_bytes`=0, `bytes_sent`=0, state IDLE.
- Reset overrides any write in the same cycle.

## Timing

- `readdata` is updated every clock from `address`. Read latency is 1 cycle, and no read strobe is required. This matches the other PIO-style slaves.
- Write accepted at edge T: level and status reflect it at T+1. If the unpacker was IDLE and the FIFO empty, `out_valid` rises at T+2.
- Steady-state throughput is 1 byte per cycle with `out_ready` held high, including across word boundaries. There is no bubble between words when the FIFO is non-empty.
- `tail_bytes` is sampled at the push edge. A later change does not affect queued words.
- `bytes_sent` wraps 0xFFFF→0x0000 with no flag.

## Test plan

- **Reset:** hold `reset` 2 cycles during a write. Required: all outputs 0; addr-0 read returns 0x00000001 (empty).
- **Single word:** write 0x64636261 to addr 2 = 0, then to addr 1, with `out_ready=1`. Required: bytes 0x61, 0x62, 0x63, 0x64 on consecutive cycles; `out_valid` first at T+2; `out_last` only on 0x64; addr-1 read = 4.
- **Tail length:** write addr 2 = 3, then addr 1 = 0x00434241. Required: 0x41, 0x42, 0x43 with `out_last` on 0x43; byte 0x00 never emitted.
- **Backpressure and back-to-back:** push 2 words via addr 0, toggle `out_ready` 1010…. Required:
  - Data is held while not ready.
  - 8 bytes arrive in order.
  - No bubble at the word boundary when `out_ready` stays 1.
  - `bytes_sent` = 8.
- **Overflow:** with `out_ready=0`, push DEPTH+2 words. Required:
  - Status shows full, level=DEPTH (plus one word busy in the unpacker), overflow=1.
  - The extra word is dropped.
  - Writing addr 3 = 2 clears overflow only.
- **Flush mid-name:** during byte 2 of a word with 3 words queued, write addr 3 = 1. Required:
  - `out_valid`=0 on the next cycle.
  - Status = empty, not busy, level 0.
  - `bytes_sent` retains its count.
  - A subsequent push streams normally.
